// File: rtl/div_seq.sv
// Sequential restoring divider with optional two's-complement operands.
// One quotient bit per cycle; divide-by-zero short-circuits straight to completion.
//
// state | meaning
// IDLE  | waiting for a start request
// CALC  | one shift-subtract iteration per cycle, WIDTH cycles total
// FIX   | apply result signs, load HI/LO, raise DIV_END
// DONE  | completion cycle; accepts a new start exactly like IDLE
`timescale 1ns/1ps
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             DIV_START,
   input  logic             SIGNED_MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             DIV_BUSY,
   output logic             DIV_END,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DIV_O
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   trial;

   // Operand magnitudes and the WIDTH+1-bit trial subtraction for the current iteration.
   // The most-negative value maps onto itself, which is the correct unsigned magnitude.
   always_comb begin
      a_neg = SIGNED_MODE & A[WIDTH-1];
      b_neg = SIGNED_MODE & B[WIDTH-1];
      a_abs = a_neg ? -A : A;
      b_abs = b_neg ? -B : B;
      trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
   end

   // Sequencer: accept, iterate, sign fix-up, completion pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         HI       <= '0;
         LO       <= '0;
         DIV_O    <= 1'b0;
         DIV_END  <= 1'b0;
         DIV_BUSY <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               DIV_END <= 1'b0;
               if (DIV_START) begin
                  if (B == '0) begin
                     // No iterations: the zero result is produced by FIX.
                     DIV_O <= 1'b1;
                     state <= FIX;
                  end else begin
                     DIV_O    <= 1'b0;
                     quo      <= a_abs;
                     dvs      <= b_abs;
                     rem      <= '0;
                     neg_q    <= a_neg ^ b_neg;
                     neg_r    <= a_neg;
                     cnt      <= CW'(WIDTH - 1);
                     DIV_BUSY <= 1'b1;
                     state    <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               // quo doubles as the dividend shift register; quotient bits fill from the bottom.
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               if (cnt == '0) begin
                  DIV_BUSY <= 1'b0;
                  state    <= FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               if (DIV_O) begin
                  HI <= '0;
                  LO <= '0;
               end else begin
                  LO <= neg_q ? -quo : quo;
                  HI <= neg_r ? -rem : rem;
               end
               DIV_END  <= 1'b1;
               DIV_BUSY <= 1'b0;
               state    <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
